// File: rtl/exec_ctrl_unit.sv
// Execute/control slice of the 32-bit MIPS-subset core: main decode, ALU control
// derivation and the ALU itself, with every result presented one clock later.
module exec_ctrl_unit #(
  parameter int SIZE = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [5:0]      opcode,
  input  logic [5:0]      funct,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  output logic            out_valid,
  output logic            regdest,
  output logic            regwrite,
  output logic            alusrc,
  output logic [1:0]      aluop,
  output logic            memread,
  output logic            memwrite,
  output logic            mem_to_reg,
  output logic            branch,
  output logic            jump,
  output logic [5:0]      alucontrol,
  output logic [SIZE-1:0] aluout,
  output logic            zero,
  output logic            cout
);

  typedef enum logic [5:0] {
    ALU_NONE = 6'd0,
    ALU_ADD  = 6'd1,
    ALU_SUB  = 6'd2,
    ALU_AND  = 6'd3,
    ALU_OR   = 6'd4,
    ALU_XOR  = 6'd5,
    ALU_NOR  = 6'd6,
    ALU_SLT  = 6'd7,
    ALU_SLL  = 6'd8,
    ALU_SRL  = 6'd9,
    ALU_SRA  = 6'd10
  } alu_op_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Control bundle order: regdest, regwrite, alusrc, aluop[1:0], memread,
  // memwrite, mem_to_reg, branch, jump.
  logic [9:0]      ctrl_s;
  alu_op_e         alu_op_s;
  logic [SIZE:0]   sum_s;
  logic [SIZE:0]   diff_s;
  logic [31:0]     shamt_s;
  logic            shamt_big_s;
  logic [SIZE-1:0] result_s;
  logic            carry_s;

  // Main decode of the opcode into datapath controls.
  always_comb begin
    ctrl_s = 10'b0_0_0_00_0_0_0_0_0;
    case (opcode)
      OP_RTYPE: ctrl_s = 10'b1_1_0_10_0_0_0_0_0;
      OP_LW:    ctrl_s = 10'b0_1_1_00_1_0_1_0_0;
      OP_SW:    ctrl_s = 10'b0_0_1_00_0_1_0_0_0;
      OP_BEQ:   ctrl_s = 10'b0_0_0_01_0_0_0_1_0;
      OP_ADDI:  ctrl_s = 10'b0_1_1_00_0_0_0_0_0;
      OP_ANDI,
      OP_ORI,
      OP_SLTI:  ctrl_s = 10'b0_1_1_11_0_0_0_0_0;
      OP_J:     ctrl_s = 10'b0_0_0_00_0_0_0_0_1;
      default:  ctrl_s = 10'b0_0_0_00_0_0_0_0_0;
    endcase
  end

  // ALU operation select from opcode, falling through to funct for R-type.
  always_comb begin
    alu_op_s = ALU_NONE;
    case (opcode)
      OP_LW, OP_SW, OP_ADDI: alu_op_s = ALU_ADD;
      OP_BEQ:                alu_op_s = ALU_SUB;
      OP_ANDI:               alu_op_s = ALU_AND;
      OP_ORI:                alu_op_s = ALU_OR;
      OP_SLTI:               alu_op_s = ALU_SLT;
      OP_RTYPE: begin
        case (funct)
          6'b100000: alu_op_s = ALU_ADD;
          6'b100010: alu_op_s = ALU_SUB;
          6'b100100: alu_op_s = ALU_AND;
          6'b100101: alu_op_s = ALU_OR;
          6'b100110: alu_op_s = ALU_XOR;
          6'b100111: alu_op_s = ALU_NOR;
          6'b101010: alu_op_s = ALU_SLT;
          6'b000000: alu_op_s = ALU_SLL;
          6'b000010: alu_op_s = ALU_SRL;
          6'b000011: alu_op_s = ALU_SRA;
          default:   alu_op_s = ALU_NONE;
        endcase
      end
      default: alu_op_s = ALU_NONE;
    endcase
  end

  // Subtraction is a + ~b + 1 so the carry out reads as "no borrow".
  assign sum_s       = {1'b0, a} + {1'b0, b};
  assign diff_s      = {1'b0, a} + {1'b0, ~b} + {{SIZE{1'b0}}, 1'b1};
  assign shamt_s     = {27'd0, b[4:0]};
  assign shamt_big_s = (shamt_s >= 32'(SIZE));

  // ALU datapath; carry is only meaningful for add and sub.
  always_comb begin
    result_s = {SIZE{1'b0}};
    carry_s  = 1'b0;
    case (alu_op_s)
      ALU_ADD: begin
        result_s = sum_s[SIZE-1:0];
        carry_s  = sum_s[SIZE];
      end
      ALU_SUB: begin
        result_s = diff_s[SIZE-1:0];
        carry_s  = diff_s[SIZE];
      end
      ALU_AND: result_s = a & b;
      ALU_OR:  result_s = a | b;
      ALU_XOR: result_s = a ^ b;
      ALU_NOR: result_s = ~(a | b);
      ALU_SLT: result_s = {{(SIZE-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLL: begin
        if (shamt_big_s) result_s = {SIZE{1'b0}};
        else             result_s = a << shamt_s;
      end
      ALU_SRL: begin
        if (shamt_big_s) result_s = {SIZE{1'b0}};
        else             result_s = a >> shamt_s;
      end
      ALU_SRA: begin
        if (shamt_big_s) result_s = {SIZE{a[SIZE-1]}};
        else             result_s = $signed(a) >>> shamt_s;
      end
      default: begin
        result_s = {SIZE{1'b0}};
        carry_s  = 1'b0;
      end
    endcase
  end

  // Output register: captures every cycle, independent of in_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      regdest    <= 1'b0;
      regwrite   <= 1'b0;
      alusrc     <= 1'b0;
      aluop      <= 2'b00;
      memread    <= 1'b0;
      memwrite   <= 1'b0;
      mem_to_reg <= 1'b0;
      branch     <= 1'b0;
      jump       <= 1'b0;
      alucontrol <= 6'd0;
      aluout     <= {SIZE{1'b0}};
      zero       <= 1'b0;
      cout       <= 1'b0;
    end else begin
      out_valid  <= in_valid;
      {regdest, regwrite, alusrc, aluop, memread, memwrite, mem_to_reg, branch, jump} <= ctrl_s;
      alucontrol <= alu_op_s;
      aluout     <= result_s;
      zero       <= (result_s == {SIZE{1'b0}});
      cout       <= carry_s;
    end
  end

endmodule

// File: tb/tb_exec_ctrl_unit.sv
// Directed self-checking bench for exec_ctrl_unit: reset behaviour, decode,
// ALU results and flags against hand-computed vectors.
module tb_exec_ctrl_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        regdest;
  logic        regwrite;
  logic        alusrc;
  logic [1:0]  aluop;
  logic        memread;
  logic        memwrite;
  logic        mem_to_reg;
  logic        branch;
  logic        jump;
  logic [5:0]  alucontrol;
  logic [31:0] aluout;
  logic        zero;
  logic        cout;
  logic [9:0]  ctrl;

  int n_checks;
  int n_errors;

  exec_ctrl_unit #(.SIZE(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .opcode(opcode), .funct(funct),
    .a(a), .b(b), .out_valid(out_valid), .regdest(regdest), .regwrite(regwrite),
    .alusrc(alusrc), .aluop(aluop), .memread(memread), .memwrite(memwrite),
    .mem_to_reg(mem_to_reg), .branch(branch), .jump(jump),
    .alucontrol(alucontrol), .aluout(aluout), .zero(zero), .cout(cout)
  );

  assign ctrl = {regdest, regwrite, alusrc, aluop, memread, memwrite, mem_to_reg, branch, jump};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one instruction and sample just after the capturing edge.
  task automatic apply(input logic v, input logic [5:0] op, input logic [5:0] fn,
                       input logic [31:0] aa, input logic [31:0] bb);
    in_valid = v; opcode = op; funct = fn; a = aa; b = bb;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; opcode = 6'b000000; funct = 6'b100000;
    a = 32'd7; b = 32'd9;
    @(posedge clk); @(posedge clk); #1;
    n_checks++;
    if ({out_valid, ctrl, alucontrol, aluout, zero, cout} !== 50'd0) begin
      n_errors++; $display("FAIL reset_init: got ctrl=%b alu=%0d out=%h v=%b z=%b c=%b want all 0",
                           ctrl, alucontrol, aluout, out_valid, zero, cout);
    end
    rst = 1'b0;
    apply(1'b1, 6'b000000, 6'b100000, 32'd2, 32'd3);
    n_checks++;
    if (aluout !== 32'd5 || out_valid !== 1'b1) begin
      n_errors++; $display("FAIL reset_pre: got out=%h v=%b want 00000005 1", aluout, out_valid);
    end
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if ({out_valid, ctrl, alucontrol, aluout, zero, cout} !== 50'd0) begin
      n_errors++; $display("FAIL reset_async: got ctrl=%b out=%h v=%b z=%b want all 0",
                           ctrl, aluout, out_valid, zero);
    end
    opcode = 6'b100011; funct = 6'b000000; a = 32'h10; b = 32'h4;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (aluout !== 32'h14 || ctrl !== 10'b0_1_1_00_1_0_1_0_0) begin
      n_errors++; $display("FAIL reset_release: got out=%h ctrl=%b want 00000014 0110010100",
                           aluout, ctrl);
    end
  endtask

  task automatic test_rtype_add();
    apply(1'b1, 6'b000000, 6'b100000, 32'hFFFF_FFFF, 32'd1);
    n_checks++;
    if ({aluout, zero, cout} !== {32'd0, 1'b1, 1'b1}) begin
      n_errors++; $display("FAIL radd_result: got out=%h z=%b c=%b want 00000000 1 1", aluout, zero, cout);
    end
    n_checks++;
    if (ctrl !== 10'b1_1_0_10_0_0_0_0_0 || alucontrol !== 6'd1 || out_valid !== 1'b1) begin
      n_errors++; $display("FAIL radd_ctrl: got ctrl=%b alu=%0d v=%b want 1101000000 1 1",
                           ctrl, alucontrol, out_valid);
    end
    apply(1'b1, 6'b000000, 6'b100010, 32'd10, 32'd3);
    n_checks++;
    if ({aluout, zero, cout, alucontrol} !== {32'd7, 1'b0, 1'b1, 6'd2}) begin
      n_errors++; $display("FAIL rsub: got out=%h z=%b c=%b alu=%0d want 00000007 0 1 2",
                           aluout, zero, cout, alucontrol);
    end
  endtask

  task automatic test_beq();
    apply(1'b1, 6'b000100, 6'b000000, 32'd5, 32'd5);
    n_checks++;
    if ({aluout, zero, cout, alucontrol} !== {32'd0, 1'b1, 1'b1, 6'd2} ||
        ctrl !== 10'b0_0_0_01_0_0_0_1_0) begin
      n_errors++; $display("FAIL beq_eq: got out=%h z=%b c=%b alu=%0d ctrl=%b want 0 1 1 2 0000100010",
                           aluout, zero, cout, alucontrol, ctrl);
    end
    apply(1'b1, 6'b000100, 6'b000000, 32'd3, 32'd5);
    n_checks++;
    if ({aluout, zero, cout} !== {32'hFFFF_FFFE, 1'b0, 1'b0}) begin
      n_errors++; $display("FAIL beq_ne: got out=%h z=%b c=%b want fffffffe 0 0", aluout, zero, cout);
    end
  endtask

  task automatic test_mem();
    apply(1'b1, 6'b100011, 6'b000000, 32'h10, 32'h4);
    n_checks++;
    if (aluout !== 32'h14 || ctrl !== 10'b0_1_1_00_1_0_1_0_0 || alucontrol !== 6'd1 || cout !== 1'b0) begin
      n_errors++; $display("FAIL lw: got out=%h ctrl=%b alu=%0d c=%b want 00000014 0110010100 1 0",
                           aluout, ctrl, alucontrol, cout);
    end
    apply(1'b1, 6'b101011, 6'b000000, 32'h10, 32'h4);
    n_checks++;
    if (aluout !== 32'h14 || ctrl !== 10'b0_0_1_00_0_1_0_0_0) begin
      n_errors++; $display("FAIL sw: got out=%h ctrl=%b want 00000014 0010001000", aluout, ctrl);
    end
  endtask

  task automatic test_logic_slt();
    apply(1'b1, 6'b001010, 6'b000000, 32'hFFFF_FFFF, 32'd1);
    n_checks++;
    if (aluout !== 32'd1 || alucontrol !== 6'd7 || ctrl !== 10'b0_1_1_11_0_0_0_0_0 || zero !== 1'b0) begin
      n_errors++; $display("FAIL slti: got out=%h alu=%0d ctrl=%b z=%b want 00000001 7 0111100000 0",
                           aluout, alucontrol, ctrl, zero);
    end
    apply(1'b1, 6'b000000, 6'b101010, 32'd1, 32'hFFFF_FFFF);
    n_checks++;
    if (aluout !== 32'd0 || zero !== 1'b1) begin
      n_errors++; $display("FAIL slt_false: got out=%h z=%b want 00000000 1", aluout, zero);
    end
    apply(1'b1, 6'b001100, 6'b000000, 32'hF0F0_00FF, 32'h0FF0_0F0F);
    n_checks++;
    if (aluout !== 32'h00F0_000F || alucontrol !== 6'd3) begin
      n_errors++; $display("FAIL andi: got out=%h alu=%0d want 00f0000f 3", aluout, alucontrol);
    end
    apply(1'b1, 6'b001101, 6'b000000, 32'hF0F0_00FF, 32'h0FF0_0F0F);
    n_checks++;
    if (aluout !== 32'hFFF0_0FFF || alucontrol !== 6'd4) begin
      n_errors++; $display("FAIL ori: got out=%h alu=%0d want fff00fff 4", aluout, alucontrol);
    end
    apply(1'b1, 6'b000000, 6'b100110, 32'hF0F0_00FF, 32'h0FF0_0F0F);
    n_checks++;
    if (aluout !== 32'hFF00_0FF0 || alucontrol !== 6'd5) begin
      n_errors++; $display("FAIL xor: got out=%h alu=%0d want ff000ff0 5", aluout, alucontrol);
    end
    apply(1'b1, 6'b000000, 6'b100111, 32'hF0F0_00FF, 32'h0FF0_0F0F);
    n_checks++;
    if (aluout !== 32'h000F_F000 || alucontrol !== 6'd6) begin
      n_errors++; $display("FAIL nor: got out=%h alu=%0d want 000ff000 6", aluout, alucontrol);
    end
  endtask

  task automatic test_shifts();
    apply(1'b1, 6'b000000, 6'b000011, 32'h8000_0000, 32'd4);
    n_checks++;
    if (aluout !== 32'hF800_0000 || alucontrol !== 6'd10 || cout !== 1'b0) begin
      n_errors++; $display("FAIL sra: got out=%h alu=%0d c=%b want f8000000 10 0", aluout, alucontrol, cout);
    end
    apply(1'b1, 6'b000000, 6'b000010, 32'h8000_0000, 32'd4);
    n_checks++;
    if (aluout !== 32'h0800_0000 || alucontrol !== 6'd9) begin
      n_errors++; $display("FAIL srl: got out=%h alu=%0d want 08000000 9", aluout, alucontrol);
    end
    apply(1'b1, 6'b000000, 6'b000000, 32'h0000_0003, 32'hFFFF_FFFF);
    n_checks++;
    if (aluout !== 32'h8000_0000 || alucontrol !== 6'd8) begin
      n_errors++; $display("FAIL sll31: got out=%h alu=%0d want 80000000 8", aluout, alucontrol);
    end
  endtask

  task automatic test_jump_illegal();
    apply(1'b1, 6'b000010, 6'b100000, 32'd9, 32'd9);
    n_checks++;
    if (ctrl !== 10'b0_0_0_00_0_0_0_0_1 || aluout !== 32'd0 || alucontrol !== 6'd0 || zero !== 1'b1) begin
      n_errors++; $display("FAIL jump: got ctrl=%b out=%h alu=%0d z=%b want 0000000001 0 0 1",
                           ctrl, aluout, alucontrol, zero);
    end
    apply(1'b1, 6'b111111, 6'b100000, 32'd9, 32'd9);
    n_checks++;
    if (ctrl !== 10'd0 || alucontrol !== 6'd0 || aluout !== 32'd0) begin
      n_errors++; $display("FAIL bad_op: got ctrl=%b alu=%0d out=%h want 0 0 0", ctrl, alucontrol, aluout);
    end
    apply(1'b1, 6'b000000, 6'b111111, 32'd9, 32'd9);
    n_checks++;
    if (alucontrol !== 6'd0 || aluout !== 32'd0 || zero !== 1'b1 || cout !== 1'b0 ||
        ctrl !== 10'b1_1_0_10_0_0_0_0_0) begin
      n_errors++; $display("FAIL bad_funct: got alu=%0d out=%h z=%b c=%b ctrl=%b want 0 0 1 0 1101000000",
                           alucontrol, aluout, zero, cout, ctrl);
    end
  endtask

  task automatic test_back_to_back();
    apply(1'b1, 6'b001000, 6'b000000, 32'h7FFF_FFFF, 32'd1);
    n_checks++;
    if (aluout !== 32'h8000_0000 || cout !== 1'b0 || out_valid !== 1'b1) begin
      n_errors++; $display("FAIL addi_wrap: got out=%h c=%b v=%b want 80000000 0 1", aluout, cout, out_valid);
    end
    apply(1'b0, 6'b001000, 6'b000000, 32'd1, 32'd2);
    n_checks++;
    if (aluout !== 32'd3 || out_valid !== 1'b0 || ctrl !== 10'b0_1_1_00_0_0_0_0_0) begin
      n_errors++; $display("FAIL invalid_capture: got out=%h v=%b ctrl=%b want 00000003 0 0110000000",
                           aluout, out_valid, ctrl);
    end
    apply(1'b1, 6'b000000, 6'b100000, 32'd0, 32'd0);
    n_checks++;
    if (out_valid !== 1'b1 || zero !== 1'b1 || cout !== 1'b0) begin
      n_errors++; $display("FAIL valid_again: got v=%b z=%b c=%b want 1 1 0", out_valid, zero, cout);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_rtype_add();
    test_beq();
    test_mem();
    test_logic_slt();
    test_shifts();
    test_jump_illegal();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/exec_ctrl_unit.md
Name: exec_ctrl_unit

Overview:
- Single-cycle execute/control slice of the 32-bit MIPS-subset processor.
- Decodes the 6-bit opcode into main datapath control signals.
- Derives a 6-bit ALU operation code from opcode and funct, and executes the ALU on operands a and b.
- All outputs are registered: one clock of latency between the inputs and the result/control bundle.

Parameters:
- SIZE, 32, ALU operand/result width in bits (minimum 8).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  inputs carry a valid instruction this cycle.
- opcode  in  6  instruction bits [31:26].
- funct  in  6  instruction bits [5:0]; used only when opcode is 000000.
- a  in  SIZE  ALU operand A (register data1).
- b  in  SIZE  ALU operand B (data2 or sign-extended immediate, muxed outside).
- out_valid  out  1  registered copy of in_valid.
- regdest  out  1  select rd (1) or rt (0) as the write register.
- regwrite  out  1  register file write enable.
- alusrc  out  1  selects the immediate for B (used by the external mux).
- aluop  out  2  00 memory/immediate add, 01 branch compare, 10 R-type, 11 immediate logic/slt.
- memread  out  1  data memory read enable.
- memwrite  out  1  data memory write enable.
- mem_to_reg  out  1  write-back selects memory data.
- branch  out  1  conditional branch instruction.
- jump  out  1  jump instruction.
- alucontrol  out  6  registered ALU operation code.
- aluout  out  SIZE  registered ALU result.
- zero  out  1  1 when aluout equals 0.
- cout  out  1  carry out of bit SIZE-1 for add/sub; 0 for all other operations.

Behaviour:
- Reset: while rst=1, every output is 0 (including out_valid, zero and cout). Release is asynchronous; first capture happens on the next rising edge.
- Each rising edge with rst=0 captures combinational decode of the current inputs into all output registers. Capture occurs regardless of in_valid; out_valid mirrors in_valid.
- Main decode (regdest, regwrite, alusrc, aluop, memread, memwrite, mem_to_reg, branch, jump):
  - R-type 000000: 1,1,0,10,0,0,0,0,0
  - lw 100011: 0,1,1,00,1,0,1,0,0
  - sw 101011: 0,0,1,00,0,1,0,0,0
  - beq 000100: 0,0,0,01,0,0,0,1,0
  - addi 001000: 0,1,1,00,0,0,0,0,0
  - andi 001100, ori 001101, slti 001010: 0,1,1,11,0,0,0,0,0
  - j 000010: all 0 except jump=1
  - any other opcode: all 0
- ALU codes: 0 none (result 0), 1 add, 2 sub, 3 and, 4 or, 5 xor, 6 nor, 7 slt (signed), 8 sll, 9 srl, 10 sra. Shift amount is b[4:0]; shifted value is a.
- ALU code mapping:
  - lw, sw, addi → 1
  - beq → 2
  - andi → 3
  - ori → 4
  - slti → 7
  - R-type funct: 100000→1, 100010→2, 100100→3, 100101→4, 100110→5, 100111→6, 101010→7, 000000→8, 000010→9, 000011→10; any other funct → 0
  - j and unknown opcodes → 0
- Arithmetic:
  - add: full SIZE+1-bit sum; cout = bit SIZE.
  - sub: computed as a + ~b + 1; cout = carry out, so cout=1 means no borrow.
  - Results wrap modulo 2^SIZE.
  - slt: result 1 if signed a < signed b, else 0.
  - sra: replicates a[SIZE-1].
  - Shift amounts ≥ SIZE give 0 for sll/srl and all sign bits for sra.
- zero is computed from the same-cycle result, so it is consistent with aluout in the same output cycle.
- Reset asserted mid-stream clears outputs immediately; there is no pipeline state other than the output register.

Test Plan:
- Reset: assert rst asynchronously between edges with outputs non-zero → all outputs 0 immediately; the first edge after release captures fresh inputs.
- R-type add: opcode 000000, funct 100000, a=0xFFFFFFFF, b=1 → next cycle aluout=0, zero=1, cout=1, regdest=1, regwrite=1, aluop=10, alucontrol=1.
- beq compare: opcode 000100, a=5, b=5 → aluout=0, zero=1, branch=1, cout=1, alucontrol=2. Repeat with a=3, b=5 → aluout=0xFFFFFFFE, zero=0, cout=0.
- lw/sw: opcode 100011, a=0x10, b=4 → aluout=0x14, memread=1, mem_to_reg=1, alusrc=1, regwrite=1. Opcode 101011 → memwrite=1, regwrite=0.
- slt and shifts:
  - slti with a=0xFFFFFFFF (−1), b=1 → aluout=1.
  - sra with a=0x80000000, b=4 → 0xF8000000.
  - srl with the same operands → 0x08000000.
- Jump and illegal codes: opcode 000010 → jump=1, other controls 0, aluout=0. Opcode 111111 → all controls 0. R-type with funct 111111 → alucontrol=0, aluout=0, zero=1.
